// File: rtl/nvme_track_update_arb_if.sv
// Request/response/tracker bundle for nvme_track_update_arb.
// master = arbiter side, slave = requesters plus tracker side.
interface nvme_track_update_arb_if #(
    parameter int ID_BITS   = 4,
    parameter int INFO_BITS = 2
);
    localparam int unsigned N = 2 ** ID_BITS;

    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic                 rsp_valid;
    logic [ID_BITS-1:0]   rsp_id;
    logic [INFO_BITS-1:0] rsp_data;
    logic                 rsp_ready;
    logic                 track_init;
    logic [N-1:0]         track_status;
    logic                 track_update;
    logic [ID_BITS-1:0]   track_update_id;
    logic                 track_update_done;
    logic [INFO_BITS-1:0] track_update_data;

    modport master (
        input  req_valid, rsp_ready, track_init, track_status,
               track_update_done, track_update_data,
        output req_ready, rsp_valid, rsp_id, rsp_data,
               track_update, track_update_id
    );

    modport slave (
        output req_valid, rsp_ready, track_init, track_status,
               track_update_done, track_update_data,
        input  req_ready, rsp_valid, rsp_id, rsp_data,
               track_update, track_update_id
    );
endinterface

// File: rtl/nvme_track_update_arb.sv
// Round-robin scheduler sharing the tracker's single track_update port.
// Optional macro NVME_TRACK_ARB_STATUS_FILTER_EN: skip polls of IDs whose track_status bit is 0.
module nvme_track_update_arb #(
    parameter int ID_BITS   = 4,
    parameter int INFO_BITS = 2
) (
    input  logic                   axi_aclk,
    input  logic                   axi_aresetn,
    nvme_track_update_arb_if.master bus
);
    localparam int unsigned N = 2 ** ID_BITS;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [ID_BITS-1:0]   ptr_q, ptr_d;
    logic [ID_BITS-1:0]   upd_id_q, upd_id_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_BITS-1:0]   rsp_id_q, rsp_id_d;
    logic [INFO_BITS-1:0] rsp_data_q, rsp_data_d;

    logic [N-1:0]         req_ready_c;
    logic [ID_BITS-1:0]   grant_id;
    logic [ID_BITS-1:0]   scan_idx;
    logic                 grant_found;

    // Scan ptr+1 .. ptr+N; the ID_BITS-wide add wraps modulo N by itself.
    always_comb begin
        grant_id    = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            scan_idx = ptr_q + ID_BITS'(i);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        upd_id_d    = upd_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        req_ready_c = '0;
        case (state_q)
            ST_INIT: begin
                if (bus.track_init) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (grant_found) begin
                    req_ready_c[grant_id] = 1'b1;
                    upd_id_d              = grant_id;
                    ptr_d                 = grant_id;
                    state_d               = ST_ISSUE;
`ifdef NVME_TRACK_ARB_STATUS_FILTER_EN
                    if (!bus.track_status[grant_id]) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_id_d    = grant_id;
                        rsp_data_d  = '0;
                    end
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.track_update_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = upd_id_q;
                    rsp_data_d  = bus.track_update_data;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

`ifndef NVME_TRACK_ARB_STATUS_FILTER_EN
    logic unused_track_status;
    assign unused_track_status = ^bus.track_status;
`endif

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= ST_INIT;
            ptr_q       <= '1;
            upd_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            upd_id_q    <= upd_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready       = req_ready_c;
    assign bus.track_update    = (state_q == ST_ISSUE);
    assign bus.track_update_id = upd_id_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_id          = rsp_id_q;
    assign bus.rsp_data        = rsp_data_q;
endmodule
